// File: rtl/umi_pkg.sv
// Shared UMI opcode constants and the write-responder FSM state encoding.
package umi_pkg;

    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WAIT = 2'd2
    } umi_state_e;

    function automatic logic is_write_op(input logic [4:0] op);
        return (op == UMI_REQ_WRITE) || (op == UMI_REQ_POSTED);
    endfunction

endpackage

// File: rtl/umi_write_resp_fifo.sv
// Response queue: DEPTH entries (power of two), wrapping pointers with an extra lap bit.
module umi_write_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

    // When full, a pop frees the head slot in the same cycle the new entry lands in it.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/umi_write_resp.sv
// UMI write responder: forwards writes to memory and queues write responses.
// Optional UMI_WRITE_RESP_COUNTERS_EN adds saturating posted/non-posted write counters.
module umi_write_resp
    import umi_pkg::*;
#(
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 256,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [CW-1:0] umi_in_cmd,
    input  logic [AW-1:0] umi_in_dstaddr,
    input  logic [AW-1:0] umi_in_srcaddr,
    input  logic [DW-1:0] umi_in_data,
    output logic          umi_in_ready,
    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    input  logic          mem_ready,
    output logic          umi_out_valid,
    output logic [CW-1:0] umi_out_cmd,
    output logic [AW-1:0] umi_out_dstaddr,
    output logic [AW-1:0] umi_out_srcaddr,
    input  logic          umi_out_ready,
    output logic          err_unsupported
`ifdef UMI_WRITE_RESP_COUNTERS_EN
    ,
    output logic [15:0]   cnt_posted,
    output logic [15:0]   cnt_write
`endif
);

    localparam int RW = CW + 2 * AW;

    umi_state_e    state_q, state_d;
    logic          live_q;
    logic          err_q, err_d;
    logic          load, push, pop, full, empty;
    logic          req_posted;
    logic [CW-1:0] req_cmd_q;
    logic [AW-1:0] req_dst_q, req_src_q;
    logic [DW-1:0] req_data_q;
    logic [RW-1:0] resp_din, resp_dout;

    // live_q keeps ready low until the first edge after reset release.
    assign umi_in_ready    = live_q && (state_q == ST_IDLE);
    assign req_posted      = (req_cmd_q[4:0] == UMI_REQ_POSTED);
    assign mem_valid       = (state_q == ST_MEM);
    assign mem_addr        = req_dst_q;
    assign mem_data        = req_data_q;
    assign err_unsupported = err_q;

    assign umi_out_valid = !empty;
    assign pop           = umi_out_valid && umi_out_ready;
    assign resp_din      = {req_cmd_q[CW-1:5], UMI_RESP_WRITE, req_src_q, req_dst_q};
    assign {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr} = resp_dout;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        push    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (umi_in_valid && umi_in_ready) begin
                    if (is_write_op(umi_in_cmd[4:0])) begin
                        load    = 1'b1;
                        state_d = ST_MEM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (req_posted) begin
                        state_d = ST_IDLE;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!full || pop) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            live_q     <= 1'b0;
            err_q      <= 1'b0;
            req_cmd_q  <= '0;
            req_dst_q  <= '0;
            req_src_q  <= '0;
            req_data_q <= '0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            err_q   <= err_d;
            if (load) begin
                req_cmd_q  <= umi_in_cmd;
                req_dst_q  <= umi_in_dstaddr;
                req_src_q  <= umi_in_srcaddr;
                req_data_q <= umi_in_data;
            end
        end
    end

    umi_write_resp_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nreset  (nreset),
        .push_i  (push),
        .din_i   (resp_din),
        .pop_i   (pop),
        .dout_o  (resp_dout),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef UMI_WRITE_RESP_COUNTERS_EN
    logic [15:0] cnt_posted_q, cnt_write_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_posted_q <= '0;
            cnt_write_q  <= '0;
        end else if (mem_valid && mem_ready) begin
            if (req_posted) begin
                if (cnt_posted_q != 16'hFFFF) cnt_posted_q <= cnt_posted_q + 16'd1;
            end else begin
                if (cnt_write_q != 16'hFFFF) cnt_write_q <= cnt_write_q + 16'd1;
            end
        end
    end

    assign cnt_posted = cnt_posted_q;
    assign cnt_write  = cnt_write_q;
`endif

endmodule

// File: tb/tb_umi_write_resp.sv
// Bench for umi_write_resp: directed scenarios plus a randomized run against a transaction-level model.
module tb_umi_write_resp;

    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          in_valid, in_ready;
    logic [CW-1:0] in_cmd;
    logic [AW-1:0] in_dst, in_src;
    logic [DW-1:0] in_data;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          out_valid, out_ready;
    logic [CW-1:0] out_cmd;
    logic [AW-1:0] out_dst, out_src;
    logic          err;
`ifdef UMI_WRITE_RESP_COUNTERS_EN
    logic [15:0]   cnt_posted, cnt_write;
`endif

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            posted;
        logic [CW-1:0] rcmd;
        logic [AW-1:0] rdst;
        logic [AW-1:0] rsrc;
    } xact_t;

    always #5 clk = ~clk;

    umi_write_resp #(.CW(CW), .AW(AW), .DW(DW), .DEPTH(4)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .umi_in_valid    (in_valid),
        .umi_in_cmd      (in_cmd),
        .umi_in_dstaddr  (in_dst),
        .umi_in_srcaddr  (in_src),
        .umi_in_data     (in_data),
        .umi_in_ready    (in_ready),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .umi_out_valid   (out_valid),
        .umi_out_cmd     (out_cmd),
        .umi_out_dstaddr (out_dst),
        .umi_out_srcaddr (out_src),
        .umi_out_ready   (out_ready),
        .err_unsupported (err)
`ifdef UMI_WRITE_RESP_COUNTERS_EN
        ,
        .cnt_posted      (cnt_posted),
        .cnt_write       (cnt_write)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Expected transaction derived from the request fields alone.
    function automatic xact_t model(input logic [CW-1:0] c, input logic [AW-1:0] d,
                                    input logic [AW-1:0] s, input logic [DW-1:0] dat);
        xact_t x;
        x.addr   = d;
        x.data   = dat;
        x.posted = (c[4:0] == 5'h05);
        x.rcmd   = c;
        x.rcmd[4:0] = 5'h04;
        x.rdst   = s;
        x.rsrc   = d;
        return x;
    endfunction

    task automatic send(input logic [CW-1:0] c, input logic [AW-1:0] d,
                        input logic [AW-1:0] s, input logic [DW-1:0] dat);
        int k;
        k = 0;
        in_valid = 1'b1; in_cmd = c; in_dst = d; in_src = s; in_data = dat;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        nvec++;
        if (in_ready !== 1'b1) begin
            nmis++;
            $display("FAIL send_accept: in_ready=%b, required 1 within 50 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 0; in_cmd = '0; in_dst = '0; in_src = '0; in_data = '0;
        mem_ready = 0; out_ready = 0;
        nreset = 0;
        tick(); tick(); tick();
        @(negedge clk);
        nvec++;
        if ({in_ready, mem_valid, out_valid, err} !== 4'b0000) begin
            nmis++;
            $display("FAIL reset_outputs: ready/mem/out/err=%b, required 0000",
                     {in_ready, mem_valid, out_valid, err});
        end
`ifdef UMI_WRITE_RESP_COUNTERS_EN
        nvec++;
        if (cnt_posted !== 16'd0 || cnt_write !== 16'd0) begin
            nmis++;
            $display("FAIL reset_counters: posted=%0d write=%0d, required 0 0", cnt_posted, cnt_write);
        end
`endif
        tick();
        nreset = 1;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b0) begin
            nmis++;
            $display("FAIL reset_release_ready_early: in_ready=%b, required 0", in_ready);
        end
        tick();
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1) begin
            nmis++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_write_latency();
        logic [CW-1:0] c;
        logic [DW-1:0] dat;
        xact_t x;
        c = 32'hABCD_E003;
        dat = rand_data();
        x = model(c, 64'h1000, 64'h2000, dat);
        tick();
        mem_ready = 1; out_ready = 1;
        in_valid = 1; in_cmd = c; in_dst = 64'h1000; in_src = 64'h2000; in_data = dat;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1) begin
            nmis++;
            $display("FAIL write_accept: in_ready=%b, required 1", in_ready);
        end
        tick();
        in_valid = 0;
        @(negedge clk);
        nvec++;
        if (mem_valid !== 1'b1 || mem_addr !== x.addr || mem_data !== x.data || out_valid !== 1'b0) begin
            nmis++;
            $display("FAIL write_mem_n1: mem_valid=%b addr=%h out_valid=%b, required 1 %h 0",
                     mem_valid, mem_addr, out_valid, x.addr);
        end
        tick();
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b1 || out_cmd !== x.rcmd || out_dst !== x.rdst || out_src !== x.rsrc) begin
            nmis++;
            $display("FAIL write_resp_n2: valid=%b cmd=%h dst=%h src=%h, required 1 %h %h %h",
                     out_valid, out_cmd, out_dst, out_src, x.rcmd, x.rdst, x.rsrc);
        end
        tick();
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || mem_valid !== 1'b0) begin
            nmis++;
            $display("FAIL write_after: out_valid=%b mem_valid=%b, required 0 0", out_valid, mem_valid);
        end
    endtask

    task automatic test_posted();
        int nmem, nresp;
        nmem = 0; nresp = 0;
        tick();
        mem_ready = 1; out_ready = 1;
        send(32'h0000_0005, 64'h5000, 64'h6000, rand_data());
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_valid && mem_ready) nmem++;
            if (out_valid) nresp++;
            tick();
        end
        nvec++;
        if (nmem != 1 || nresp != 0) begin
            nmis++;
            $display("FAIL posted_counts: mem=%0d resp=%0d, required 1 0", nmem, nresp);
        end
`ifdef UMI_WRITE_RESP_COUNTERS_EN
        nvec++;
        if (cnt_posted !== 16'd1 || cnt_write !== 16'd1) begin
            nmis++;
            $display("FAIL posted_counters: posted=%0d write=%0d, required 1 1", cnt_posted, cnt_write);
        end
`endif
    endtask

    task automatic test_unsupported();
        int bad;
        bad = 0;
        mem_ready = 1; out_ready = 1;
        in_valid = 1; in_cmd = 32'h0000_0001; in_dst = 64'h7000; in_src = 64'h8000; in_data = rand_data();
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || err !== 1'b0) begin
            nmis++;
            $display("FAIL unsup_accept: ready=%b err=%b, required 1 0", in_ready, err);
        end
        tick();
        in_valid = 0;
        @(negedge clk);
        nvec++;
        if (err !== 1'b1 || mem_valid !== 1'b0) begin
            nmis++;
            $display("FAIL unsup_pulse: err=%b mem_valid=%b, required 1 0", err, mem_valid);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (err || mem_valid || out_valid) bad++;
            tick();
        end
        nvec++;
        if (bad != 0) begin
            nmis++;
            $display("FAIL unsup_quiet: %0d cycles with err/mem/out activity, required 0", bad);
        end
    endtask

    task automatic fill_five(output xact_t q[5]);
        logic [CW-1:0] c;
        logic [DW-1:0] dat;
        out_ready = 0; mem_ready = 1;
        for (int i = 0; i < 5; i++) begin
            c = $urandom;
            c[4:0] = 5'h03;
            dat = rand_data();
            q[i] = model(c, 64'h4000 + 64'(i), 64'h3000 + 64'(i), dat);
            send(c, 64'h4000 + 64'(i), 64'h3000 + 64'(i), dat);
        end
    endtask

    task automatic test_backpressure();
        xact_t q[5];
        int n, bad;
        bad = 0; n = 0;
        tick();
        fill_five(q);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            tick();
        end
        nvec++;
        if (bad != 0) begin
            nmis++;
            $display("FAIL bp_wait: %0d cycles with ready!=0 or out_valid!=1, required 0", bad);
        end
        out_ready = 1;
        @(negedge clk);
        nvec++;
        if (out_cmd !== q[0].rcmd || out_dst !== q[0].rdst || out_src !== q[0].rsrc) begin
            nmis++;
            $display("FAIL bp_head: cmd=%h dst=%h src=%h, required %h %h %h",
                     out_cmd, out_dst, out_src, q[0].rcmd, q[0].rdst, q[0].rsrc);
        end
        tick();
        out_ready = 0;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            nmis++;
            $display("FAIL bp_after_pop: ready=%b out_valid=%b, required 1 1", in_ready, out_valid);
        end
        tick();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (n < 4) begin
                    nvec++;
                    if (out_src !== q[n+1].rsrc || out_dst !== q[n+1].rdst || out_cmd !== q[n+1].rcmd) begin
                        nmis++;
                        $display("FAIL bp_drain[%0d]: src=%h dst=%h, required %h %h",
                                 n, out_src, out_dst, q[n+1].rsrc, q[n+1].rdst);
                    end
                end
                n++;
            end
            tick();
        end
        nvec++;
        if (n != 4) begin
            nmis++;
            $display("FAIL bp_drain_count: %0d responses, required 4", n);
        end
    endtask

    task automatic test_mem_stall();
        logic [CW-1:0] c;
        logic [DW-1:0] dat;
        xact_t x;
        int bad, k;
        bad = 0; k = 0;
        c = $urandom; c[4:0] = 5'h03;
        dat = rand_data();
        x = model(c, 64'hDEAD_0000, 64'hBEEF_0000, dat);
        mem_ready = 0; out_ready = 1;
        send(c, 64'hDEAD_0000, 64'hBEEF_0000, dat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_valid !== 1'b1 || mem_addr !== x.addr || mem_data !== x.data || in_ready !== 1'b0) bad++;
            tick();
        end
        nvec++;
        if (bad != 0) begin
            nmis++;
            $display("FAIL stall_hold: %0d cycles with unstable mem payload or ready high, required 0", bad);
        end
        mem_ready = 1;
        @(negedge clk);
        while (!out_valid && k < 5) begin
            tick();
            @(negedge clk);
            k++;
        end
        nvec++;
        if (out_valid !== 1'b1 || out_src !== x.rsrc || out_dst !== x.rdst) begin
            nmis++;
            $display("FAIL stall_resp: valid=%b src=%h dst=%h, required 1 %h %h",
                     out_valid, out_src, out_dst, x.rsrc, x.rdst);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        xact_t q[5];
        int bad;
        bad = 0;
        tick();
        fill_five(q);
        tick(); tick();
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            nmis++;
            $display("FAIL rst_wait_pre: ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
        end
        tick();
        nreset = 0;
        @(negedge clk);
        nvec++;
        if ({in_ready, mem_valid, out_valid, err} !== 4'b0000) begin
            nmis++;
            $display("FAIL rst_wait_assert: ready/mem/out/err=%b, required 0000",
                     {in_ready, mem_valid, out_valid, err});
        end
        tick(); tick();
        nreset = 1;
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b0) begin
            nmis++;
            $display("FAIL rst_wait_early_ready: ready=%b, required 0", in_ready);
        end
        tick();
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nmis++;
            $display("FAIL rst_wait_release: ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            if (out_valid || mem_valid) bad++;
        end
        nvec++;
        if (bad != 0) begin
            nmis++;
            $display("FAIL rst_wait_flushed: %0d cycles with stale activity, required 0", bad);
        end
`ifdef UMI_WRITE_RESP_COUNTERS_EN
        nvec++;
        if (cnt_posted !== 16'd0 || cnt_write !== 16'd0) begin
            nmis++;
            $display("FAIL rst_wait_counters: posted=%0d write=%0d, required 0 0", cnt_posted, cnt_write);
        end
`endif
    endtask

    task automatic test_random();
        xact_t exp_mem[$];
        xact_t exp_resp[$];
        xact_t x, f;
        logic [CW-1:0] c;
        logic hs_in, hs_mem, hs_out, err_exp;
        int r, nposted, nwrite;
        err_exp = 0; nposted = 0; nwrite = 0;
        tick();
        in_valid = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            hs_in  = in_valid && in_ready;
            hs_mem = mem_valid && mem_ready;
            hs_out = out_valid && out_ready;
            nvec++;
            if (err !== err_exp) begin
                nmis++;
                $display("FAIL rand_err cyc %0d: err=%b, required %b", cyc, err, err_exp);
            end
            err_exp = hs_in && !(in_cmd[4:0] == 5'h03 || in_cmd[4:0] == 5'h05);
            if (hs_out) begin
                nvec++;
                if (exp_resp.size() == 0) begin
                    nmis++;
                    $display("FAIL rand_resp_spurious cyc %0d: src=%h, required no response", cyc, out_src);
                end else begin
                    f = exp_resp.pop_front();
                    if (out_cmd !== f.rcmd || out_dst !== f.rdst || out_src !== f.rsrc) begin
                        nmis++;
                        $display("FAIL rand_resp cyc %0d: cmd=%h dst=%h src=%h, required %h %h %h",
                                 cyc, out_cmd, out_dst, out_src, f.rcmd, f.rdst, f.rsrc);
                    end
                end
            end
            if (hs_mem) begin
                nvec++;
                if (exp_mem.size() == 0) begin
                    nmis++;
                    $display("FAIL rand_mem_spurious cyc %0d: addr=%h, required no transfer", cyc, mem_addr);
                end else begin
                    f = exp_mem.pop_front();
                    if (mem_addr !== f.addr || mem_data !== f.data) begin
                        nmis++;
                        $display("FAIL rand_mem cyc %0d: addr=%h, required %h", cyc, mem_addr, f.addr);
                    end
                    if (f.posted) nposted++;
                    else begin
                        nwrite++;
                        exp_resp.push_back(f);
                    end
                end
            end
            if (hs_in && (in_cmd[4:0] == 5'h03 || in_cmd[4:0] == 5'h05))
                exp_mem.push_back(model(in_cmd, in_dst, in_src, in_data));
            tick();
            if (!in_valid || hs_in) begin
                in_valid = (cyc < 500) && ($urandom_range(0, 2) != 0);
                r = $urandom_range(0, 9);
                c = $urandom;
                if (r < 4)      c[4:0] = 5'h03;
                else if (r < 7) c[4:0] = 5'h05;
                else if (r == 7) c[4:0] = 5'h04;
                else if (r == 8) c[4:0] = 5'h01;
                in_cmd = c; in_dst = {$urandom, $urandom}; in_src = {$urandom, $urandom};
                in_data = rand_data();
            end
            mem_ready = (cyc >= 500) || ($urandom_range(0, 3) != 0);
            out_ready = (cyc >= 500) || ($urandom_range(0, 2) != 0);
        end
        nvec++;
        if (exp_mem.size() != 0 || exp_resp.size() != 0 || in_valid !== 1'b0) begin
            nmis++;
            $display("FAIL rand_drain: mem pending %0d resp pending %0d, required 0 0",
                     exp_mem.size(), exp_resp.size());
        end
`ifdef UMI_WRITE_RESP_COUNTERS_EN
        nvec++;
        if (cnt_posted !== 16'(nposted) || cnt_write !== 16'(nwrite)) begin
            nmis++;
            $display("FAIL rand_counters: posted=%0d write=%0d, required %0d %0d",
                     cnt_posted, cnt_write, nposted, nwrite);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_posted();
        test_unsupported();
        test_backpressure();
        test_mem_stall();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/umi_write_resp.md
UMI_WRITE_RESP -- requirements
Module: umi_write_resp

Interface
REQ-001 Parameter CW, default 32: command width.
REQ-002 Parameter AW, default 64: address width.
REQ-003 Parameter DW, default 256: data width.
REQ-004 Parameter DEPTH, default 4: response FIFO entries, power of two, at least 2.
REQ-005 One clock; reset is asynchronous and active-low: port clk, input, 1, clock; port nreset, input, 1, async active-low reset.
REQ-006 Request ports: umi_in_valid in 1; umi_in_cmd in CW; umi_in_dstaddr in AW; umi_in_srcaddr in AW; umi_in_data in DW; umi_in_ready out 1.
REQ-007 Memory ports: mem_valid out 1; mem_addr out AW; mem_data out DW; mem_ready in 1.
REQ-008 Response ports: umi_out_valid out 1; umi_out_cmd out CW; umi_out_dstaddr out AW; umi_out_srcaddr out AW; umi_out_ready in 1.
REQ-009 Status port: err_unsupported out 1, one-cycle pulse.

Function
REQ-010 Opcode is cmd[4:0]: 5'h03 is write (non-posted), 5'h05 is posted write, 5'h04 is write response.
REQ-011 A valid/ready transfer occurs on a rising clk edge with valid and ready both high; a valid SHALL hold its payload stable until the transfer.
REQ-012 The FSM SHALL have three states: IDLE, MEM and WAIT.
REQ-013 umi_in_ready = (state==IDLE).
REQ-014 IDLE: on an accepted write or posted write, register cmd/dstaddr/srcaddr/data and go to MEM.
REQ-015 IDLE: on an accepted request with any other opcode, pulse err_unsupported for 1 cycle, drop the request and stay in IDLE.
REQ-016 MEM: mem_valid=1, mem_addr=registered dstaddr, mem_data=registered data; mem_valid=0 in all other states.
REQ-017 MEM, on mem handshake, posted write: go to IDLE; no response is generated.
REQ-018 MEM, on mem handshake, non-posted write with FIFO not full: push the response and go to IDLE.
REQ-019 MEM, on mem handshake, non-posted write with FIFO full: go to WAIT.
REQ-020 WAIT: push when FIFO not full, or when FIFO full and a pop occurs in the same cycle, then go to IDLE.
REQ-021 Response fields: cmd = {req_cmd[CW-1:5], 5'h04}; dstaddr = req srcaddr; srcaddr = req dstaddr.
REQ-022 FIFO: pointers are log2(DEPTH)+1 bits and wrap; full and empty are derived from pointer compare.
REQ-023 Simultaneous push and pop at any occupancy SHALL leave the count unchanged.
REQ-024 umi_out_valid = !empty; umi_out_* = head entry; pop on the output handshake.
REQ-025 Latency: request accepted at cycle N gives mem_valid at N+1; with mem_ready high at N+1, umi_out_valid rises at N+2 when the FIFO was empty.
REQ-026 Throughput: at most one request per 2 cycles.

Reset
REQ-027 While nreset is low: state=IDLE, FIFO empty, and umi_in_ready, mem_valid, umi_out_valid and err_unsupported all 0.
REQ-028 Reset asserted mid-transaction SHALL discard the in-flight request and all queued responses.
REQ-029 umi_in_ready SHALL rise on the first clk edge after nreset deasserts.

Configuration
REQ-030 Macro UMI_WRITE_RESP_COUNTERS_EN defined: add outputs cnt_posted and cnt_write, each 16-bit.
REQ-031 With UMI_WRITE_RESP_COUNTERS_EN defined: each counter increments on the matching mem handshake, saturates at 16'hFFFF, and resets to 0.
REQ-032 UMI_WRITE_RESP_COUNTERS_EN undefined: these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-033 Opcode constants (UMI_REQ_WRITE, UMI_REQ_POSTED, UMI_RESP_WRITE) and the FSM state encoding SHALL live in shared package umi_pkg.
REQ-034 The response queue SHALL be sub-module umi_write_resp_fifo, parameterised by width and DEPTH.

Verification
REQ-035 Write cmd 0x03, dst 0x1000, src 0x2000, mem_ready=1, out_ready=1 -> mem_addr=0x1000 at N+1; response cmd[4:0]=0x04, dst 0x2000, src 0x1000 at N+2.
REQ-036 Posted write 0x05 -> exactly one mem transfer and zero responses; cnt_posted=1 when UMI_WRITE_RESP_COUNTERS_EN is defined.
REQ-037 Opcode 0x01 -> err_unsupported high 1 cycle, no mem_valid, no response.
REQ-038 out_ready=0, 5 writes -> 4 queued, FSM in WAIT, umi_in_ready=0; one pop -> 5th pushed the same cycle, FIFO count stays 4.
REQ-039 mem_ready held low 10 cycles -> mem_valid and payload stable for 10 cycles, umi_in_ready=0 throughout.
REQ-040 nreset pulsed low in WAIT with 4 queued -> umi_out_valid=0, FIFO empty, umi_in_ready=1 one cycle after release.
